rca_multiword_sequencer: RTL
============================

Name: rca_multiword_sequencer

Overview:
Multi-cycle wide-operand adder controller. It adds two W-bit operands (W = N*SLICES) by time-sharing one N-bit ripple_carry_adder across SLICES consecutive cycles, least significant slice first. A registered carry links each slice to the next. Used wherever wide additions are needed but area budget allows only one narrow adder; start/busy/done handshake toward the issuing logic.

Parameters:
N, 4, slice width = width of the shared ripple_carry_adder instance
SLICES, 4, number of slices per operation (>=2); localparam W = N*SLICES

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled on rising edge
a  input  W  operand A, captured on the accepting edge only
b  input  W  operand B, captured on the accepting edge only
cin  input  1  carry-in to slice 0, captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result registers valid and freshly updated
sum  output  W  registered result; held until the next completion
cout  output  1  registered final carry-out
ovf  output  1  registered signed overflow: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using captured operands

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, cout, ovf = 0; sum = 0; internal operand, partial-sum, carry and slice counter registers cleared. Reset mid-RUN aborts the operation. No done pulse; sum keeps its reset value 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge (E0) captures a, b, cin into internal shift registers. Slice counter=0. Goes to RUN.
- RUN: busy=1. Each edge Ek (k=1..SLICES) applies captured slice k-1 of a and b plus the carry register to the adder. It writes the N-bit slice sum into the partial-sum register at slice k-1 and stores the adder cout in the carry register. Counter increments.
  - At E_SLICES: sum <= full partial result including the last slice; cout <= last slice carry-out; ovf computed as above. Goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 at the next edge is accepted as in IDLE (back-to-back operations); goes to RUN.
  - Otherwise goes to IDLE.
- Latency: start accepted at E0 gives done high in the cycle following E_SLICES. sum, cout and ovf are valid from that cycle on.
- Throughput: one operation per SLICES+1 cycles.
- start while in RUN: ignored. Captured operands are not disturbed; no queueing.
- a, b and cin may change freely after the accepting edge.
- Width rules:
  - Slice arithmetic is strictly N-bit plus carry, with no wider intermediate.
  - The carry register is 1 bit.
  - sum wraps modulo 2^W; cout reports the carry beyond bit W-1.
- Only one adder instance exists. No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package/include rca_seq_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - counter-width helper (clog2 of SLICES)
- Sub-module: one instance of the existing ripple_carry_adder (#(.N(N))) for slice arithmetic.
- Controller FSM, operand shift registers and result registers live in this module. No further sub-modules.

Test Plan:
1. N=4, SLICES=4: a=16'hFFFF, b=16'h0001, cin=0, start pulse at E0 -> busy high E0..E4, done high exactly one cycle after E4, sum=16'h0000, cout=1, ovf=0.
2. a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; then a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
3. Carry chain across slices: a=16'h00FF, b=16'h0000, cin=1 -> sum=16'h0100, cout=0. Also a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555.
4. start re-asserted during RUN with different a/b -> ignored; result matches the first operands; done pulses once.
5. rst asserted asynchronously at mid-RUN (after E2) -> busy, done, sum, cout, ovf immediately 0; next start after release completes normally with correct result.
6. Back-to-back: start held high through DONE cycle with new operands -> second operation accepted at the DONE edge, second done pulse exactly SLICES+1 cycles after the first, both results correct.

Source files
------------

// File: rtl/rca_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rca_seq_pkg: shared state encoding and sizing helper for the        |
// | multi-word ripple-carry sequencer.            Revision: 1.0         |
// +--------------------------------------------------------------------+
package rca_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Slice counter width; never narrower than one bit.
    function automatic int cnt_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ripple_carry_adder: N-bit adder built from a chain of full adders.  |
// |                                               Revision: 1.0         |
// +--------------------------------------------------------------------+
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[N];

endmodule
`default_nettype wire

// File: rtl/rca_multiword_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rca_multiword_sequencer: W-bit add performed one N-bit slice per    |
// | cycle on a single shared ripple-carry adder.  Revision: 1.0         |
// +--------------------------------------------------------------------+
module rca_multiword_sequencer
    import rca_seq_pkg::*;
#(
    parameter int N      = 4,
    parameter int SLICES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*SLICES-1:0] a,
    input  logic [N*SLICES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [N*SLICES-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int W  = N * SLICES;
    localparam int CW = cnt_width(SLICES);
    localparam logic [CW-1:0] C_LAST_SLICE = CW'(SLICES - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_psum;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic [N-1:0]  w_ssum;
    logic          w_scout;
    logic [W-1:0]  w_full;

    ripple_carry_adder #(.N(N)) u_adder (
        .a    (r_a[N-1:0]),
        .b    (r_b[N-1:0]),
        .cin  (r_carry),
        .sum  (w_ssum),
        .cout (w_scout)
    );

    // Operands shift down one slice per cycle; results enter from the top,
    // so after SLICES steps the partial sum is aligned with slice 0 at the bottom.
    assign w_full = {w_ssum, r_psum[W-1:N]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= {{N{1'b0}}, r_a[W-1:N]};
                    r_b     <= {{N{1'b0}}, r_b[W-1:N]};
                    r_psum  <= w_full;
                    r_carry <= w_scout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST_SLICE) begin
                        // The top slice of the captured operands holds the sign bits now.
                        r_sum   <= w_full;
                        r_cout  <= w_scout;
                        r_ovf   <= (r_a[N-1] == r_b[N-1]) && (w_ssum[N-1] != r_a[N-1]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
